ctx_width_chunk_adder: RTL and testbench

- Sequential, handshaked adder for two unsigned operands of unequal width.
- Applies SystemVerilog 11.6 expression-width rules at run time:
  - context-determined mode: both operands zero-extended to the result width before the add;
  - self-determined mode: add performed at max(A_W,B_W) bits, then result zero-extended (the `{a+b}` case).
- Adds CHUNK_W bits per cycle with a registered carry.
- Serves as the execution-stage reference model downstream of the width-inference lowering. It checks Zext/IntBinaryArith(Add) sequences in simulation.

---
 rtl/ctx_width_chunk_adder.sv | 128 ++++++++++++
 tb/tb_ctx_width_chunk_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ctx_width_chunk_adder.sv
// Chunk-serial unsigned adder that follows SystemVerilog expression-width rules at run time.
// Context mode adds on OUT_W bits. Self mode adds on max(A_W,B_W) bits and zero-extends the result.
module ctx_width_chunk_adder #(
  parameter int A_W     = 15,
  parameter int B_W     = 16,
  parameter int OUT_W   = 17,
  parameter int CHUNK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_self,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic             out_carry
);

  localparam int SW = (A_W > B_W) ? A_W : B_W;
  localparam int N  = (OUT_W + CHUNK_W - 1) / CHUNK_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  generate
    if (A_W < 1 || B_W < 1 || OUT_W < SW || CHUNK_W < 1 || CHUNK_W > OUT_W) begin : g_bad_params
      $error("ctx_width_chunk_adder: illegal parameters (need OUT_W >= max(A_W,B_W), 1 <= CHUNK_W <= OUT_W)");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE. out_valid is high only in DONE, with out_sum/out_carry held until out_ready.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [OUT_W-1:0] op_a, op_b, sum_r, sum_next;
  logic             self_r, carry_r, carry_next, cap_hit, cap_val;
  logic [KW-1:0]    k;
  logic [IW-1:0]    idx;
  logic             ab, bb;
  int               pos;

  // Ripple through one chunk, bit by bit. The carry is captured at the add-width boundary.
  // In self mode the carry is killed there, so the zeroed upper operand bits produce zero sum bits.
  always_comb begin
    sum_next   = sum_r;
    carry_next = carry_r;
    cap_hit    = 1'b0;
    cap_val    = 1'b0;
    pos        = 0;
    idx        = '0;
    ab         = 1'b0;
    bb         = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pos = int'(k) * CHUNK_W + i;
      if (pos < OUT_W) begin
        idx           = IW'(pos);
        ab            = op_a[idx];
        bb            = op_b[idx];
        sum_next[idx] = ab ^ bb ^ carry_next;
        carry_next    = (ab & bb) | (carry_next & (ab ^ bb));
        if (self_r && pos == SW - 1) begin
          cap_hit    = 1'b1;
          cap_val    = carry_next;
          carry_next = 1'b0;
        end else if (!self_r && pos == OUT_W - 1) begin
          cap_hit = 1'b1;
          cap_val = carry_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_carry <= 1'b0;
      sum_r     <= '0;
      carry_r   <= 1'b0;
      k         <= '0;
      op_a      <= '0;
      op_b      <= '0;
      self_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a      <= OUT_W'(in_a);
            op_b      <= OUT_W'(in_b);
            self_r    <= in_self;
            sum_r     <= '0;
            carry_r   <= 1'b0;
            out_carry <= 1'b0;
            k         <= '0;
            in_ready  <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          sum_r   <= sum_next;
          carry_r <= carry_next;
          if (cap_hit) out_carry <= cap_val;
          if (k == KW'(N - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sum = sum_r;

endmodule

// File: tb/tb_ctx_width_chunk_adder.sv
// Bench for ctx_width_chunk_adder: four instances with CHUNK_W = 1, 4, 5 and 17 share one clock and reset.
// Expected {carry,sum} values are queued when a transaction is driven and compared when out_valid rises.
module tb_ctx_width_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_self, out_ready;
  wire  [3:0]  in_ready, out_valid, out_carry;
  logic [14:0] in_a [4];
  logic [15:0] in_b [4];
  wire  [16:0] out_sum [4];

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 5 : 17;
    ctx_width_chunk_adder #(.A_W(15), .B_W(16), .OUT_W(17), .CHUNK_W(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .in_self   (in_self[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_sum   (out_sum[g]),
      .out_carry (out_carry[g])
    );
  end

  function automatic int n_of(input int u);
    case (u)
      0: return 17;
      1: return 5;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: context adds on 17 bits, self adds on 16 bits and zero-extends.
  function automatic logic [17:0] model(input logic [14:0] a, input logic [15:0] b, input bit s);
    logic [17:0] full;
    full = {3'b000, a} + {2'b00, b};
    if (s) return {full[16], 1'b0, full[15:0]};
    return full;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int u);
    check("idle_rdy", 32'(in_ready[u]), 1);
    check("idle_vld", 32'(out_valid[u]), 0);
    check("idle_sum", 32'(out_sum[u]), 0);
    check("idle_cry", 32'(out_carry[u]), 0);
  endtask

  task automatic run_txn(input int u, input logic [14:0] a, input logic [15:0] b, input bit s,
                         input int hold);
    logic [17:0] e;
    int lat;
    exp_q.push_back(model(a, b, s));
    @(negedge clk);
    check("pre_rdy", 32'(in_ready[u]), 1);
    in_valid[u]  = 1'b1;
    in_a[u]      = a;
    in_b[u]      = b;
    in_self[u]   = s;
    out_ready[u] = (hold == 0);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    in_a[u]     = 15'($urandom);
    in_b[u]     = 16'($urandom);
    in_self[u]  = ~s;
    check("busy_rdy", 32'(in_ready[u]), 0);
    lat = 0;
    while (!out_valid[u] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = exp_q.pop_front();
    if (!out_valid[u]) begin
      check("timeout", 0, 1);
      out_ready[u] = 1'b0;
      return;
    end
    check("latency", 32'(lat), 32'(n_of(u)));
    check("sum", 32'(out_sum[u]), 32'(e[16:0]));
    check("carry", 32'(out_carry[u]), 32'(e[17]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_vld", 32'(out_valid[u]), 1);
      check("hold_rdy", 32'(in_ready[u]), 0);
      check("hold_sum", 32'(out_sum[u]), 32'(e[16:0]));
      check("hold_cry", 32'(out_carry[u]), 32'(e[17]));
    end
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    check("post_vld", 32'(out_valid[u]), 0);
    check("post_rdy", 32'(in_ready[u]), 1);
    out_ready[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = '0;
    in_self   = '0;
    out_ready = '0;
    for (int u = 0; u < 4; u++) begin
      in_a[u] = '0;
      in_b[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) check_idle(u);
    end

    run_txn(1, 15'h7FFF, 16'hFFFF, 1'b0, 0);
    run_txn(1, 15'h7FFF, 16'hFFFF, 1'b1, 0);
    run_txn(1, 15'h0001, 16'h0002, 1'b0, 3);

    // Abort in the second BUSY cycle: nothing may come out.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_a[1]     = 15'h1234;
    in_b[1]     = 16'h4321;
    in_self[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle(1);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid[1]) seen++;
    end
    check("abort_quiet", 32'(seen), 0);
    out_ready[1] = 1'b0;
    run_txn(1, 15'h0001, 16'h0001, 1'b0, 0);

    // Reset wins over a simultaneous in_valid.
    @(negedge clk);
    rst = 1'b1;
    in_valid[2] = 1'b1;
    in_a[2] = 15'h0005;
    in_b[2] = 16'h0005;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    check("rst_win_rdy", 32'(in_ready[2]), 1);
    check("rst_win_vld", 32'(out_valid[2]), 0);

    for (int u = 0; u < 4; u++) begin
      run_txn(u, 15'h7FFF, 16'hFFFF, 1'b0, 0);
      run_txn(u, 15'h7FFF, 16'hFFFF, 1'b1, 0);
    end

    for (int t = 0; t < 12; t++) begin
      run_txn(int'($urandom_range(0, 3)), 15'($urandom_range(0, 32767)),
              16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)));
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
